lm07_spi_responder: RTL and testbench

- Synthesizable SPI temperature-sensor responder: the slave end of the LM07 CS/SCK/SIO read interface.
- Used on FPGA builds as a stand-in sensor, and as a silicon-equivalent peer for the LM07 reader master.
- Oversamples the master's CS/SCK on SYSCLK and shifts a held 16-bit temperature word out on SIO, MSB first.
- Host logic updates the temperature word through a parallel load port.

---
 rtl/lm07_pkg.sv | 14 +
 rtl/lm07_sync_edge.sv | 38 +++
 rtl/lm07_spi_responder.sv | 170 +++++++++++++++++
 tb/tb_lm07_spi_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm07_pkg.sv
// Shared definitions for the LM07 serial temperature interface (reader and responder).
package lm07_pkg;

    // Responder frame state
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } lm07_state_e;

    localparam int unsigned LM07_DATA_W   = 16;
    localparam logic [15:0] LM07_TEMP_SET = 16'h0F00;

endpackage

// File: rtl/lm07_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module lm07_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the pin into the chain; remember the last stage for edge compare
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge pulses, consumed by the next clock edge of the user
    always_comb begin
        rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

endmodule

// File: rtl/lm07_spi_responder.sv
// LM07-style SPI slave: shifts a held temperature word out on SIO, MSB first,
// on falling SCK while CS is low. CS/SCK are oversampled on SYSCLK.
module lm07_spi_responder
    import lm07_pkg::*;
#(
    parameter int unsigned       DATA_W      = LM07_DATA_W,
    parameter logic [DATA_W-1:0] RESET_TEMP  = LM07_TEMP_SET,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              SCK,
    output logic              SIO,
    output logic              SIO_OE,
    input  logic [DATA_W-1:0] TEMP_IN,
    input  logic              TEMP_VLD,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              FRAME_ABORT,
    output logic [4:0]        BITCNT
);

    localparam logic [4:0] FullCnt = 5'(DATA_W);

    logic cs_rise, cs_fall;
    logic sck_rise, sck_fall;

    lm07_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] ret_word;

    lm07_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .clk_i  (SYSCLK),
        .rst_i  (RST),
        .d_i    (CS),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    lm07_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk_i  (SYSCLK),
        .rst_i  (RST),
        .d_i    (SCK),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // SCK rise needs no action: the master samples SIO on that edge
    logic unused_sck_rise;
    assign unused_sck_rise = sck_rise;

    // Frame FSM, shift path and temperature holding/pending registers
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bitcnt_d   = bitcnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        // Word that becomes current when a frame ends; a strobe on that very
        // cycle is newest and wins over an older pending value
        if (TEMP_VLD) begin
            ret_word = TEMP_IN;
        end else if (pend_vld_q) begin
            ret_word = pend_q;
        end else begin
            ret_word = hold_q;
        end

        unique case (state_q)
            StIdle: begin
                // Idle update also refreshes shift_reg so SIO previews the new MSB
                if (TEMP_VLD) begin
                    hold_d  = TEMP_IN;
                    shift_d = TEMP_IN;
                end
                if (cs_fall) begin
                    state_d  = StShift;
                    bitcnt_d = '0;
                    shift_d  = TEMP_VLD ? TEMP_IN : hold_q;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    // CS rise outranks a coincident SCK fall
                    state_d    = StIdle;
                    abort_d    = 1'b1;
                    hold_d     = ret_word;
                    shift_d    = ret_word;
                    pend_vld_d = 1'b0;
                end else begin
                    if (TEMP_VLD) begin
                        pend_d     = TEMP_IN;
                        pend_vld_d = 1'b1;
                    end
                    if (sck_fall) begin
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == FullCnt - 5'd1) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (cs_rise) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    hold_d     = ret_word;
                    shift_d    = ret_word;
                    pend_vld_d = 1'b0;
                end else if (TEMP_VLD) begin
                    pend_d     = TEMP_IN;
                    pend_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q    <= StIdle;
            shift_q    <= RESET_TEMP;
            hold_q     <= RESET_TEMP;
            pend_q     <= RESET_TEMP;
            pend_vld_q <= 1'b0;
            bitcnt_q   <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bitcnt_q   <= bitcnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        SIO         = shift_q[DATA_W-1];
        SIO_OE      = (state_q != StIdle);
        BUSY        = (state_q == StShift) || (state_q == StDone);
        FRAME_DONE  = done_q;
        FRAME_ABORT = abort_q;
        BITCNT      = bitcnt_q;
    end

endmodule

// File: tb/tb_lm07_spi_responder.sv
// Directed bench for lm07_spi_responder acting as an LM07 reader master.
module tb_lm07_spi_responder;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        cs;
    logic        sck;
    logic        sio;
    logic        sio_oe;
    logic [15:0] temp_in;
    logic        temp_vld;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic [4:0]  bitcnt;

    int nvec = 0;
    int nerr = 0;

    always #10 sysclk = ~sysclk;

    lm07_spi_responder dut (
        .SYSCLK      (sysclk),
        .RST         (rst),
        .CS          (cs),
        .SCK         (sck),
        .SIO         (sio),
        .SIO_OE      (sio_oe),
        .TEMP_IN     (temp_in),
        .TEMP_VLD    (temp_vld),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done),
        .FRAME_ABORT (frame_abort),
        .BITCNT      (bitcnt)
    );

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge sysclk);
    endtask

    // Master: sample SIO, raise SCK, 100 ns high, fall, 100 ns low
    task automatic clock_bits(input int n, inout logic [15:0] rd);
        for (int i = 0; i < n; i++) begin
            rd  = {rd[14:0], sio};
            sck = 1'b1;
            wait_cyc(5);
            sck = 1'b0;
            wait_cyc(5);
        end
    endtask

    task automatic end_frame(output int nd, output int na, output logic [4:0] bc);
        cs = 1'b1;
        nd = 0;
        na = 0;
        bc = '0;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(1);
            if (frame_done) begin
                nd++;
                bc = bitcnt;
            end
            if (frame_abort) begin
                na++;
                bc = bitcnt;
            end
        end
        wait_cyc(2);
    endtask

    task automatic strobe(input logic [15:0] v);
        temp_in  = v;
        temp_vld = 1'b1;
        wait_cyc(1);
        temp_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; temp_in = '0; temp_vld = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        nvec++;
        if (sio !== 1'b0) begin nerr++; $display("FAIL reset_sio: got %b want 0", sio); end
        nvec++;
        if (sio_oe !== 1'b0) begin nerr++; $display("FAIL reset_oe: got %b want 0", sio_oe); end
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++;
        if (bitcnt !== 5'd0) begin nerr++; $display("FAIL reset_bitcnt: got %0d want 0", bitcnt); end
        nvec++;
        if (dut.hold_q !== 16'h0F00) begin
            nerr++; $display("FAIL reset_hold: got %h want 0f00", dut.hold_q);
        end
        wait_cyc(5);
        nvec++;
        if (sio_oe !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            nerr++; $display("FAIL reset_idle_cs_high: oe/done/abort %b%b%b want 000",
                             sio_oe, frame_done, frame_abort);
        end
    endtask

    task automatic test_full_frame;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        nvec++;
        if (busy !== 1'b1 || sio_oe !== 1'b1) begin
            nerr++; $display("FAIL frame_start: busy %b oe %b want 1 1", busy, sio_oe);
        end
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'h0F00) begin nerr++; $display("FAIL full_read: got %h want 0f00", rd); end
        nvec++;
        if (bitcnt !== 5'd16) begin nerr++; $display("FAIL full_bitcnt: got %0d want 16", bitcnt); end
        nvec++;
        if (sio !== 1'b0 || busy !== 1'b1) begin
            nerr++; $display("FAIL full_done_state: sio %b busy %b want 0 1", sio, busy);
        end
        end_frame(nd, na, bc);
        nvec++;
        if (nd != 1 || na != 0) begin
            nerr++; $display("FAIL full_pulses: done %0d abort %0d want 1 0", nd, na);
        end
        nvec++;
        if (busy !== 1'b0 || sio_oe !== 1'b0) begin
            nerr++; $display("FAIL full_end_busy: busy %b oe %b want 0 0", busy, sio_oe);
        end
    endtask

    task automatic test_idle_update;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        rd = '0;
        strobe(16'hA5C3);
        wait_cyc(2);
        nvec++;
        if (sio !== 1'b1) begin nerr++; $display("FAIL idle_sio_preview: got %b want 1", sio); end
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'hA5C3) begin nerr++; $display("FAIL idle_update_read: got %h want a5c3", rd); end
        end_frame(nd, na, bc);
        nvec++;
        if (nd != 1) begin nerr++; $display("FAIL idle_update_done: got %0d want 1", nd); end
    endtask

    task automatic test_mid_update;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(8, rd);
        strobe(16'h1234);
        wait_cyc(1);
        strobe(16'h5678);
        clock_bits(8, rd);
        nvec++;
        if (rd !== 16'hA5C3) begin nerr++; $display("FAIL mid_cur_read: got %h want a5c3", rd); end
        nvec++;
        if (dut.hold_q !== 16'hA5C3) begin
            nerr++; $display("FAIL mid_hold_kept: got %h want a5c3", dut.hold_q);
        end
        end_frame(nd, na, bc);
        nvec++;
        if (sio !== 1'b0) begin nerr++; $display("FAIL mid_idle_sio: got %b want 0", sio); end
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'h5678) begin nerr++; $display("FAIL mid_next_read: got %h want 5678", rd); end
        end_frame(nd, na, bc);
    endtask

    task automatic test_abort;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(5, rd);
        nvec++;
        if (rd[4:0] !== 5'b01010) begin nerr++; $display("FAIL abort_partial: got %b want 01010", rd[4:0]); end
        end_frame(nd, na, bc);
        nvec++;
        if (na != 1 || nd != 0) begin
            nerr++; $display("FAIL abort_pulses: abort %0d done %0d want 1 0", na, nd);
        end
        nvec++;
        if (bc !== 5'd5) begin nerr++; $display("FAIL abort_bitcnt: got %0d want 5", bc); end
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'h5678) begin nerr++; $display("FAIL abort_next_read: got %h want 5678", rd); end
        end_frame(nd, na, bc);
        nvec++;
        if (nd != 1 || na != 0) begin
            nerr++; $display("FAIL abort_next_pulses: done %0d abort %0d want 1 0", nd, na);
        end
    endtask

    task automatic test_fall_bypass;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        rd = '0;
        cs = 1'b0;
        wait_cyc(2);
        strobe(16'h8001);
        wait_cyc(2);
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'h8001) begin nerr++; $display("FAIL bypass_read: got %h want 8001", rd); end
        end_frame(nd, na, bc);
        nvec++;
        if (dut.hold_q !== 16'h8001) begin
            nerr++; $display("FAIL bypass_hold: got %h want 8001", dut.hold_q);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        int nd, na;
        logic [4:0] bc;
        int bad;
        rd = '0;
        bad = 0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(9, rd);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sck = 1'b1;
            wait_cyc(5);
            if (sio_oe !== 1'b0 || bitcnt !== 5'd0) bad++;
            sck = 1'b0;
            wait_cyc(5);
            if (sio_oe !== 1'b0 || bitcnt !== 5'd0) bad++;
        end
        nvec++;
        if (bad != 0) begin nerr++; $display("FAIL rst_mid_quiet: %0d bad samples want 0", bad); end
        end_frame(nd, na, bc);
        nvec++;
        if (nd != 0 || na != 0) begin
            nerr++; $display("FAIL rst_mid_no_pulse: done %0d abort %0d want 0 0", nd, na);
        end
        rd = '0;
        cs = 1'b0;
        wait_cyc(5);
        clock_bits(16, rd);
        nvec++;
        if (rd !== 16'h0F00) begin nerr++; $display("FAIL rst_mid_next_read: got %h want 0f00", rd); end
        end_frame(nd, na, bc);
        nvec++;
        if (nd != 1) begin nerr++; $display("FAIL rst_mid_next_done: got %0d want 1", nd); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_idle_update();
        test_mid_update();
        test_abort();
        test_fall_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
